// File: rtl/vscale_hasti_sram_ws.sv
// HASTI (AHB-lite) slave SRAM with configurable depth and OKAY-response wait states.
// Optional build macro VSCALE_HASTI_SRAM_STATS_EN adds saturating read/write/error counters.
module vscale_hasti_sram_ws #(
  parameter int NWORDS      = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
`ifdef VSCALE_HASTI_SRAM_STATS_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_err
`endif
);

  localparam int         AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          accept;
  logic          illegal;
  logic [3:0]    mask;
  logic [31:0]   mem [NWORDS];

  // Bus attributes this slave does not interpret.
  logic unused_in;
  assign unused_in = ^{hburst, hmastlock, hprot};

  assign accept  = hready && htrans[1];
  assign illegal = (hsize > 3'd2)
                || (hsize == 3'd1 && haddr[0])
                || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                || ({2'b00, haddr[31:2]} >= 32'(NWORDS));

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hready   = 1'b1;
    hresp    = 1'b0;
    case (state)
      S_WAIT: begin
        hready = 1'b0;
        if (cnt <= 3'd1) state_nx = S_LAST;
        else             cnt_nx   = cnt - 3'd1;
      end
      S_ERR1: begin
        hready   = 1'b0;
        hresp    = 1'b1;
        state_nx = S_ERR2;
      end
      default: begin
        // IDLE, LAST and ERR2 all complete a phase and may accept a new address phase.
        hresp = (state == S_ERR2);
        if (hready && htrans[1]) begin
          if (illegal) begin
            state_nx = S_ERR1;
          end else if (WS == 3'd0) begin
            state_nx = S_LAST;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WS;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        idx_q   <= haddr[AW+1:2];
        off_q   <= haddr[1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    case (size_q)
      3'd0:    mask = 4'b0001 << off_q;
      3'd1:    mask = 4'b0011 << off_q;
      default: mask = 4'b1111;
    endcase
  end

  // NOTE: the array has no reset; contents survive hresetn and only LAST of a write changes them.
  always_ff @(posedge hclk) begin
    if (state == S_LAST && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (state == S_LAST) ? mem[idx_q] : 32'd0;

`ifdef VSCALE_HASTI_SRAM_STATS_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      stat_rd  <= 16'd0;
      stat_wr  <= 16'd0;
      stat_err <= 16'd0;
    end else begin
      if (state == S_LAST && !write_q && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      if (state == S_LAST && write_q && stat_wr != 16'hFFFF)  stat_wr <= stat_wr + 16'd1;
      if (state == S_ERR2 && stat_err != 16'hFFFF)            stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_hasti_sram_ws.sv
// Directed bench for vscale_hasti_sram_ws: instance 0 has no wait states, instance 1 has three
// and a small depth. Define VSCALE_HASTI_SRAM_STATS_EN to also exercise the counters.
module tb_vscale_hasti_sram_ws;

  localparam int NW0 = 1024;
  localparam int NW1 = 64;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hwrite [2];
  logic        hready [2];
  logic        hresp [2];
  logic [2:0]  hsize [2];
  logic [2:0]  hburst [2];
  logic        hmastlock [2];
  logic [3:0]  hprot [2];
  logic [1:0]  htrans [2];

  int checks   = 0;
  int failures = 0;

`ifdef VSCALE_HASTI_SRAM_STATS_EN
  logic [15:0] stat_rd [2];
  logic [15:0] stat_wr [2];
  logic [15:0] stat_err [2];
`endif

  vscale_hasti_sram_ws #(.NWORDS(NW0), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
    .hburst(hburst[0]), .hmastlock(hmastlock[0]), .hprot(hprot[0]), .htrans(htrans[0]),
    .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hready(hready[0]), .hresp(hresp[0])
`ifdef VSCALE_HASTI_SRAM_STATS_EN
    , .stat_rd(stat_rd[0]), .stat_wr(stat_wr[0]), .stat_err(stat_err[0])
`endif
  );

  vscale_hasti_sram_ws #(.NWORDS(NW1), .WAIT_STATES(3)) u1 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
    .hburst(hburst[1]), .hmastlock(hmastlock[1]), .hprot(hprot[1]), .htrans(htrans[1]),
    .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hready(hready[1]), .hresp(hresp[1])
`ifdef VSCALE_HASTI_SRAM_STATS_EN
    , .stat_rd(stat_rd[1]), .stat_wr(stat_wr[1]), .stat_err(stat_err[1])
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus(input int d);
    htrans[d]    = 2'b00;
    hwrite[d]    = 1'b0;
    haddr[d]     = 32'd0;
    hsize[d]     = 3'd2;
    hwdata[d]    = 32'd0;
    hburst[d]    = 3'b011;
    hmastlock[d] = 1'b1;
    hprot[d]     = 4'hF;
  endtask

  function automatic int ok_cycles(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Single non-pipelined transfer; the data-phase loop is bounded at 20 cycles.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int ncyc,
                      output logic first_ready, output logic first_resp, output logic last_resp);
    logic done;
    haddr[d]  = a;
    hwrite[d] = wr;
    hsize[d]  = sz;
    htrans[d] = 2'b10;
    step();
    htrans[d] = 2'b00;
    hwdata[d] = wdata;
    ncyc = 0; rdata = 32'd0; first_ready = 1'b0; first_resp = 1'b0; last_resp = 1'b0;
    do begin
      @(negedge hclk);
      ncyc++;
      if (ncyc == 1) begin
        first_ready = hready[d];
        first_resp  = hresp[d];
      end
      rdata     = hrdata[d];
      last_resp = hresp[d];
      done      = hready[d];
      step();
    end while (!done && ncyc < 20);
    hwdata[d] = 32'd0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] v);
    logic [31:0] r; int n; logic fr, fp, lp;
    xfer(d, a, 1'b1, sz, v, r, n, fr, fp, lp);
    checks++;
    if (n !== ok_cycles(d) || lp !== 1'b0) begin
      failures++;
      $display("FAIL write_cycles d%0d @%h: got %0d cycles resp %b, expected %0d cycles resp 0",
               d, a, n, lp, ok_cycles(d));
    end
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r; int n; logic fr, fp, lp;
    xfer(d, a, 1'b0, 3'd2, 32'd0, r, n, fr, fp, lp);
    checks++;
    if (n !== ok_cycles(d) || lp !== 1'b0) begin
      failures++;
      $display("FAIL %s_cycles: got %0d cycles resp %b, expected %0d cycles resp 0",
               name, n, lp, ok_cycles(d));
    end
    checks++;
    if (r !== exp) begin
      failures++;
      $display("FAIL %s_data: got %h, expected %h", name, r, exp);
    end
  endtask

  task automatic expect_err(input int d, input logic [31:0] a, input logic [2:0] sz, input string name);
    logic [31:0] r; int n; logic fr, fp, lp;
    xfer(d, a, 1'b1, sz, 32'hFFFF_FFFF, r, n, fr, fp, lp);
    checks++;
    if ({fr, fp} !== 2'b01 || lp !== 1'b1 || n !== 2) begin
      failures++;
      $display("FAIL %s: got first ready/resp %b%b, final resp %b, %0d cycles; expected 01, 1, 2 cycles",
               name, fr, fp, lp, n);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    idle_bus(0);
    idle_bus(1);
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hready[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs d%0d: got ready %b resp %b rdata %h, expected 1 0 00000000",
                 d, hready[d], hresp[d], hrdata[d]);
      end
    end
    @(negedge hclk);
    hresetn = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2; htrans[0] = 2'b10;
    step();
    hwdata[0] = 32'hDEAD_BEEF; hwrite[0] = 1'b0; htrans[0] = 2'b10;
    @(negedge hclk);
    checks++;
    if (hready[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_write_ready: got %b, expected 1", hready[0]);
    end
    step();
    idle_bus(0);
    @(negedge hclk);
    checks++;
    if (hready[0] !== 1'b1 || hresp[0] !== 1'b0 || hrdata[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL b2b_read: got ready %b resp %b rdata %h, expected 1 0 deadbeef",
               hready[0], hresp[0], hrdata[0]);
    end
    step();
    @(negedge hclk);
    checks++;
    if (hready[0] !== 1'b1 || hrdata[0] !== 32'd0) begin
      failures++;
      $display("FAIL b2b_idle: got ready %b rdata %h, expected 1 00000000", hready[0], hrdata[0]);
    end
    step();
  endtask

  task automatic test_wait_states();
    int lows; logic seen; logic [31:0] got;
    wr(1, 32'h20, 3'd2, 32'hA5A5_5A5A);
    haddr[1] = 32'h20; hwrite[1] = 1'b0; hsize[1] = 3'd2; htrans[1] = 2'b10;
    step();
    haddr[1] = 32'h24;
    lows = 0; seen = 1'b0; got = 32'd0;
    do begin
      @(negedge hclk);
      if (hready[1]) begin
        seen = 1'b1;
        got = hrdata[1];
        htrans[1] = 2'b00;
      end else begin
        lows++;
      end
      step();
    end while (!seen && lows < 10);
    checks++;
    if (lows !== 3 || !seen) begin
      failures++;
      $display("FAIL wait_count: got %0d low cycles (completed %b), expected 3 (completed 1)", lows, seen);
    end
    checks++;
    if (got !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL wait_read_data: got %h, expected a5a55a5a", got);
    end
    @(negedge hclk);
    checks++;
    if (hready[1] !== 1'b1 || hrdata[1] !== 32'd0) begin
      failures++;
      $display("FAIL wait_no_accept: got ready %b rdata %h, expected 1 00000000", hready[1], hrdata[1]);
    end
    step();
    idle_bus(1);
  endtask

  task automatic test_byte_lanes();
    wr(0, 32'h40, 3'd2, 32'h0000_0000);
    wr(0, 32'h41, 3'd0, 32'hFFFF_AAFF);
    wr(0, 32'h42, 3'd1, 32'h1234_FFFF);
    rd_chk(0, 32'h40, 32'h1234_AA00, "lanes_byte_half");
    wr(0, 32'h40, 3'd0, 32'hFFFF_FFBB);
    rd_chk(0, 32'h40, 32'h1234_AABB, "lanes_byte0");
    wr(1, 32'h30, 3'd2, 32'h0000_0000);
    wr(1, 32'h33, 3'd0, 32'h77FF_FFFF);
    rd_chk(1, 32'h30, 32'h7700_0000, "lanes_byte3_ws");
  endtask

  task automatic test_errors();
    wr(0, 32'h0, 3'd2, 32'h1122_3344);
    wr(0, 32'h4, 3'd2, 32'h5566_7788);
    expect_err(0, 32'h3, 3'd1, "err_half_misaligned");
    expect_err(0, 32'h6, 3'd2, "err_word_misaligned");
    expect_err(0, 32'h0, 3'd3, "err_size3");
    expect_err(0, NW0 * 4, 3'd2, "err_range");
    rd_chk(0, 32'h0, 32'h1122_3344, "err_word0_kept");
    rd_chk(0, 32'h4, 32'h5566_7788, "err_word1_kept");
    wr(0, (NW0 - 1) * 4, 3'd2, 32'h0BAD_CAFE);
    rd_chk(0, (NW0 - 1) * 4, 32'h0BAD_CAFE, "last_word_ok");
    wr(1, 32'h0, 3'd2, 32'h0101_0101);
    wr(1, 32'h8, 3'd2, 32'hCAFE_0001);
    expect_err(1, 32'hA, 3'd2, "err_ws_misaligned");
    expect_err(1, NW1 * 4, 3'd2, "err_ws_range");
    expect_err(1, 32'h8, 3'd4, "err_ws_size4");
    rd_chk(1, 32'h8, 32'hCAFE_0001, "err_ws_kept");
    rd_chk(1, 32'h0, 32'h0101_0101, "err_ws_alias_kept");
    wr(1, (NW1 - 1) * 4, 3'd2, 32'h6060_6060);
    rd_chk(1, (NW1 - 1) * 4, 32'h6060_6060, "ws_last_word_ok");
  endtask

  task automatic test_idle_busy();
    wr(0, 32'h0, 3'd2, 32'hCAFE_F00D);
    haddr[0] = 32'h0; hwrite[0] = 1'b1; hsize[0] = 3'd2; hwdata[0] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      htrans[0] = (i < 2) ? 2'b00 : 2'b01;
      @(negedge hclk);
      checks++;
      if (hready[0] !== 1'b1 || hresp[0] !== 1'b0) begin
        failures++;
        $display("FAIL idle_busy_%0d: got ready %b resp %b, expected 1 0", i, hready[0], hresp[0]);
      end
      step();
    end
    idle_bus(0);
    rd_chk(0, 32'h0, 32'hCAFE_F00D, "idle_busy_no_write");
  endtask

  task automatic test_reset_in_wait();
    wr(1, 32'h0C, 3'd2, 32'h1357_9BDF);
    haddr[1] = 32'h0C; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'b10;
    step();
    htrans[1] = 2'b00;
    hwdata[1] = 32'hFFFF_0000;
    @(negedge hclk);
    checks++;
    if (hready[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_entered: got ready %b, expected 0", hready[1]);
    end
    #1 hresetn = 1'b0;
    #1;
    checks++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0 || hrdata[1] !== 32'd0) begin
      failures++;
      $display("FAIL rst_async: got ready %b resp %b rdata %h, expected 1 0 00000000",
               hready[1], hresp[1], hrdata[1]);
    end
    step();
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    idle_bus(1);
    rd_chk(1, 32'h0C, 32'h1357_9BDF, "rst_no_write");
  endtask

`ifdef VSCALE_HASTI_SRAM_STATS_EN
  task automatic test_stats();
    @(negedge hclk);
    hresetn = 1'b0;
    #1;
    checks++;
    if (stat_rd[0] !== 16'd0 || stat_wr[0] !== 16'd0 || stat_err[0] !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset: got %0d/%0d/%0d, expected 0/0/0", stat_rd[0], stat_wr[0], stat_err[0]);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    rd_chk(0, 32'h0, 32'hCAFE_F00D, "stats_rd0");
    rd_chk(0, 32'h4, 32'h5566_7788, "stats_rd1");
    wr(0, 32'h8, 3'd2, 32'h0000_0008);
    wr(0, 32'hC, 3'd2, 32'h0000_000C);
    expect_err(0, 32'h1, 3'd2, "stats_err");
    rd_chk(0, 32'h8, 32'h0000_0008, "stats_rd2");
    checks++;
    if (stat_rd[0] !== 16'd3 || stat_wr[0] !== 16'd2 || stat_err[0] !== 16'd1) begin
      failures++;
      $display("FAIL stats_counts: got rd %0d wr %0d err %0d, expected 3 2 1",
               stat_rd[0], stat_wr[0], stat_err[0]);
    end
    haddr[0] = 32'h0; hwrite[0] = 1'b0; hsize[0] = 3'd2; htrans[0] = 2'b10;
    repeat (70000) step();
    idle_bus(0);
    step();
    step();
    checks++;
    if (stat_rd[0] !== 16'hFFFF || stat_wr[0] !== 16'd2 || stat_err[0] !== 16'd1) begin
      failures++;
      $display("FAIL stats_saturate: got rd %h wr %0d err %0d, expected ffff 2 1",
               stat_rd[0], stat_wr[0], stat_err[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_idle_busy();
    test_reset_in_wait();
`ifdef VSCALE_HASTI_SRAM_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
